// File: rtl/benchmark_parity_pipe.sv
// Parity pipeline: captures two operand vectors and a 2-bit combine mode,
// forms a per-bit term, and XOR-reduces the terms across STAGES register
// stages followed by a registered output. A saturating counter tallies
// results that came out as 1.
module benchmark_parity_pipe #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             clr,
    output logic             out,
    output logic             out_valid,
    output logic [CNT_W-1:0] ones_count,
    output logic             count_sat
);

    // Stage 1 holds NG partial parities; each later stage halves the count,
    // so the last stage carries the full parity in bit 0 and zeros above.
    localparam int NG = 1 << (STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             in_v_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] term;
    logic [NG-1:0]    grp;
    logic [STAGES:1]  vld_q;
    logic [NG-1:0]    part_q [1:STAGES];

    function automatic logic [NG-1:0] pair_xor(input logic [NG-1:0] p);
        logic [NG-1:0] r;
        r = '0;
        for (int g = 0; g < NG / 2; g++) begin
            r[g] = p[2*g] ^ p[2*g+1];
        end
        return r;
    endfunction

    // Input capture: operands and mode are held with the sample so that a
    // later mode change cannot affect samples already in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in_v_q <= 1'b0;
            mode_q <= 2'b00;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            in_v_q <= in_valid;
            if (in_valid) begin
                mode_q <= mode;
                a_q    <= a_in;
                b_q    <= b_in;
            end
        end
    end

    // Per-bit combine function selected by the captured mode.
    always_comb begin
        term = '0;
        case (mode_q)
            2'b00:   term = a_q ^ b_q;
            2'b01:   term = a_q | b_q;
            2'b10:   term = a_q & b_q;
            default: term = ~a_q | b_q;
        endcase
    end

    // Interleaved split of the terms into NG equal-as-possible groups.
    always_comb begin
        grp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            grp[i % NG] = grp[i % NG] ^ term[i];
        end
    end

    // Reduction pipeline with a valid bit per stage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int s = 1; s <= STAGES; s++) begin
                part_q[s] <= '0;
            end
        end else begin
            vld_q[1]  <= in_v_q;
            part_q[1] <= grp;
            for (int s = 2; s <= STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                part_q[s] <= pair_xor(part_q[s-1]);
            end
        end
    end

    // Output register: out only moves when a valid result arrives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld_q[STAGES];
            if (vld_q[STAGES]) begin
                out <= ^part_q[STAGES];
            end
        end
    end

    // Saturating ones counter; clr takes priority over an increment.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ones_count <= '0;
        end else if (clr) begin
            ones_count <= '0;
        end else if (out_valid && out && (ones_count != CNT_MAX)) begin
            ones_count <= ones_count + 1'b1;
        end
    end

    assign count_sat = (ones_count == CNT_MAX);

endmodule

// File: tb/tb_benchmark_parity_pipe.sv
// Self-checking bench for benchmark_parity_pipe (WIDTH=6, STAGES=2, CNT_W=8).
// Reference model: parity from whole-vector ops, a 3-deep sample queue for
// latency, and an integer saturating counter.
module tb_benchmark_parity_pipe;

    logic       clock;
    logic       resetn;
    logic       in_valid;
    logic [1:0] mode;
    logic [5:0] a_in;
    logic [5:0] b_in;
    logic       clr;
    logic       out;
    logic       out_valid;
    logic [7:0] ones_count;
    logic       count_sat;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit v;
        bit p;
    } samp_t;

    samp_t hist[$];
    bit    m_ov;
    bit    m_out;
    int    m_cnt;

    benchmark_parity_pipe #(.WIDTH(6), .STAGES(2), .CNT_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .mode       (mode),
        .a_in       (a_in),
        .b_in       (b_in),
        .clr        (clr),
        .out        (out),
        .out_valid  (out_valid),
        .ones_count (ones_count),
        .count_sat  (count_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_parity(input logic [1:0] md, input logic [5:0] a, input logic [5:0] b);
        logic [5:0] t;
        case (md)
            2'b00:   t = a ^ b;
            2'b01:   t = a | b;
            2'b10:   t = a & b;
            default: t = ~a | b;
        endcase
        return ($countones(t) % 2) == 1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('{v: 1'b0, p: 1'b0});
        m_ov  = 1'b0;
        m_out = 1'b0;
        m_cnt = 0;
    endtask

    task automatic drive(input bit v, input logic [1:0] md, input logic [5:0] a,
                         input logic [5:0] b, input bit c);
        in_valid = v;
        mode     = md;
        a_in     = a;
        b_in     = b;
        clr      = c;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        samp_t e;
        @(posedge clock);
        #1;
        if (clr)
            m_cnt = 0;
        else if (m_ov && m_out && m_cnt < 255)
            m_cnt = m_cnt + 1;
        e = hist.pop_front();
        hist.push_back('{v: in_valid, p: model_parity(mode, a_in, b_in)});
        m_ov = e.v;
        if (e.v) m_out = e.p;
        chk("out_valid",  {31'd0, out_valid}, {31'd0, m_ov});
        chk("out",        {31'd0, out},       {31'd0, m_out});
        chk("ones_count", {24'd0, ones_count}, m_cnt);
        chk("count_sat",  {31'd0, count_sat}, (m_cnt == 255) ? 32'd1 : 32'd0);
    endtask

    initial begin
        resetn = 1'b1;
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        model_reset();
        #2 resetn = 1'b0;
        #1;
        chk("rst out",        {31'd0, out}, 0);
        chk("rst out_valid",  {31'd0, out_valid}, 0);
        chk("rst ones_count", {24'd0, ones_count}, 0);
        chk("rst count_sat",  {31'd0, count_sat}, 0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Single sample, mode 00 -> parity 1, 3-cycle latency
        drive(1, 2'b00, 6'b000001, 6'b000000, 0);
        cycle();
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        cycle();
        chk("lat1 early", {31'd0, out_valid}, 0);
        cycle();
        chk("lat1 early", {31'd0, out_valid}, 0);
        cycle();
        chk("lat1 strobe", {31'd0, out_valid}, 1);
        chk("lat1 out",    {31'd0, out}, 1);
        cycle();
        chk("lat1 count",  {24'd0, ones_count}, 1);
        chk("lat1 single", {31'd0, out_valid}, 0);
        chk("lat1 hold",   {31'd0, out}, 1);

        // Back-to-back samples with a mode change between them
        drive(1, 2'b10, 6'b111111, 6'b000111, 0);
        cycle();
        drive(1, 2'b11, 6'b111111, 6'b000000, 0);
        cycle();
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        cycle();
        cycle();
        chk("b2b first v", {31'd0, out_valid}, 1);
        chk("b2b first",   {31'd0, out}, 1);
        cycle();
        chk("b2b second v", {31'd0, out_valid}, 1);
        chk("b2b second",   {31'd0, out}, 0);
        chk("b2b count",    {24'd0, ones_count}, 2);
        cycle();
        chk("b2b end", {31'd0, out_valid}, 0);

        // Asynchronous reset with samples in flight
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b00, 6'b000001, 6'b000000, 0);
            cycle();
        end
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        #2 resetn = 1'b0;
        #1;
        chk("arst out",        {31'd0, out}, 0);
        chk("arst out_valid",  {31'd0, out_valid}, 0);
        chk("arst ones_count", {24'd0, ones_count}, 0);
        chk("arst count_sat",  {31'd0, count_sat}, 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("arst flushed", {31'd0, out_valid}, 0);
        end
        drive(1, 2'b01, 6'b000000, 6'b100000, 0);
        cycle();
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        cycle();
        cycle();
        chk("post rst early", {31'd0, out_valid}, 0);
        cycle();
        chk("post rst strobe", {31'd0, out_valid}, 1);
        chk("post rst out",    {31'd0, out}, 1);
        cycle();
        chk("post rst count",  {24'd0, ones_count}, 1);

        // Saturation
        for (int i = 0; i < 256; i++) begin
            drive(1, 2'b00, 6'b000001, 6'b000000, 0);
            cycle();
        end
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        for (int i = 0; i < 6; i++) cycle();
        chk("sat count", {24'd0, ones_count}, 255);
        chk("sat flag",  {31'd0, count_sat}, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 6'b000001, 6'b000000, 0);
            cycle();
        end
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        for (int i = 0; i < 6; i++) cycle();
        chk("sat hold count", {24'd0, ones_count}, 255);
        chk("sat hold flag",  {31'd0, count_sat}, 1);

        // clr together with an out=1 strobe while saturated
        drive(1, 2'b00, 6'b000001, 6'b000000, 0);
        cycle();
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        cycle();
        cycle();
        cycle();
        chk("clr strobe", {31'd0, out_valid}, 1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr sat count", {24'd0, ones_count}, 0);
        chk("clr sat flag",  {31'd0, count_sat}, 0);

        // clr winning over a live increment below saturation
        drive(1, 2'b00, 6'b000001, 6'b000000, 0);
        cycle();
        cycle();
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        cycle();
        cycle();
        cycle();
        chk("clr inc pre", {24'd0, ones_count}, 1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr inc count", {24'd0, ones_count}, 0);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  $urandom_range(0, 63) == 0);
            cycle();
        end
        drive(0, 2'b00, 6'h00, 6'h00, 0);
        for (int i = 0; i < 5; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/benchmark_parity_pipe.md
BENCHMARK_PARITY_PIPE -- requirements
Module: benchmark_parity_pipe

Interface
REQ-001 Parameter WIDTH, default 6: bit width of operand vectors a_in and b_in; legal range 1..64.
REQ-002 Parameter STAGES, default 2: pipeline register stages after input capture; legal range 1..4.
REQ-003 Parameter CNT_W, default 8: width of the ones-event counter.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  qualifies a_in, b_in and mode in the current cycle.
REQ-007 mode  input  2  per-bit combine function select, sampled with in_valid.
REQ-008 a_in  input  WIDTH  operand A.
REQ-009 b_in  input  WIDTH  operand B.
REQ-010 clr  input  1  synchronous clear of ones_count and count_sat.
REQ-011 out  output  1  registered parity result.
REQ-012 out_valid  output  1  one-cycle strobe marking out as new.
REQ-013 ones_count  output  CNT_W  number of results with out=1 since reset or clr.
REQ-014 count_sat  output  1  high while ones_count is at its maximum value.

Function
REQ-015 On a clock edge with in_valid=1, the block SHALL capture a_in, b_in and mode into the input stage; with in_valid=0 the stage SHALL be marked invalid.
REQ-016 Per-bit term t[i] SHALL be: mode 00 -> a[i]^b[i]; 01 -> a[i]|b[i]; 10 -> a[i]&b[i]; 11 -> ~a[i]|b[i].
REQ-017 The result SHALL be the XOR reduction of t[WIDTH-1:0], computed across the STAGES pipeline stages, with the reduction tree split evenly where WIDTH allows.
REQ-018 Each stage SHALL carry a valid bit; no backpressure; one new sample per cycle SHALL be accepted.
REQ-019 Latency SHALL be exactly STAGES+1 cycles: in_valid sampled at edge n -> out_valid=1 and out updated after edge n+STAGES+1.
REQ-020 out_valid SHALL be high for exactly one cycle per accepted sample; back-to-back samples SHALL give back-to-back strobes in order.
REQ-021 out SHALL hold its last value while out_valid=0.
REQ-022 On each cycle with out_valid=1 and out=1, ones_count SHALL increment by 1.
REQ-023 ones_count SHALL saturate at 2^CNT_W-1 (no wrap); count_sat SHALL be 1 exactly while ones_count equals that value.
REQ-024 clr=1 SHALL set ones_count to 0 and count_sat to 0 at the next edge; clr with a simultaneous increment SHALL give 0 (clr wins).
REQ-025 A mode change between samples SHALL affect only samples captured with the new mode; in-flight samples SHALL keep their captured mode.

Reset
REQ-026 resetn=0 SHALL immediately, without waiting for a clock edge, force out=0, out_valid=0, ones_count=0, count_sat=0, and clear all stage valid bits.
REQ-027 Samples in flight when reset asserts SHALL be discarded and SHALL produce no out_valid after release.
REQ-028 The first sample accepted after resetn deasserts SHALL obey the REQ-019 latency.

Verification (WIDTH=6, STAGES=2, CNT_W=8)
REQ-029 mode=00, a=000001, b=000000, one-cycle in_valid -> out_valid pulse exactly 3 cycles later with out=1; ones_count=1.
REQ-030 mode=10, a=111111, b=000111, then mode=11, a=111111, b=000000 on consecutive cycles -> two consecutive strobes with out=1 then out=0; ones_count +1.
REQ-031 256 samples each producing out=1 -> ones_count reaches 255, count_sat=1, and both stay there; clr in the same cycle as a further out=1 strobe -> ones_count=0, count_sat=0.
REQ-032 Three samples in flight, resetn pulsed low mid-cycle -> outputs zero immediately (asynchronous), no out_valid after release; next sample has 3-cycle latency.
REQ-033 Random in_valid, mode and operands for 10k cycles -> out/out_valid match a reference parity model delayed by 3 cycles; ones_count matches the model count.
